// File: rtl/arith_pkg.sv
// Shared decode constants and ALU operation encoding for the RV32I arithmetic unit.
// Also holds the helper that maps funct3 and the alternate bit to an ALU operation.
package arith_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
  } alu_op_e;

  // alt is inst[30]; it only turns ADD into SUB for register-register forms,
  // while it always selects arithmetic right shift for both forms.
  function automatic alu_op_e decode_funct3(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_imm);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = (alt && !is_imm) ? SUB : ADD;
      F3_SLL:     op = SLL;
      F3_SLT:     op = SLT;
      F3_SLTU:    op = SLTU;
      F3_XOR:     op = XOR;
      F3_SR:      op = alt ? SRA : SRL;
      F3_OR:      op = OR;
      default:    op = AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/arith_alu_core.sv
// Purely combinational 32-bit integer ALU.
// Shifts use only b[4:0]; add/sub wrap; compares return 0 or 1.
module alu_core
  import arith_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ADD:    result = a + b;
      SUB:    result = a - b;
      SLL:    result = a << shamt;
      SLT:    result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:   result = {{(DATA_W-1){1'b0}}, (a < b)};
      XOR:    result = a ^ b;
      SRL:    result = a >> shamt;
      SRA:    result = $unsigned($signed(a) >>> shamt);
      OR:     result = a | b;
      AND:    result = a & b;
      PASS_B: result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/arith.sv
// RV32I integer execution unit: decodes OP, OP-IMM, LUI and AUIPC, computes the
// result with alu_core and registers it for writeback one cycle after issue.
module arith
  import arith_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            arith_request_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] rs1_value_i,
  input  logic [XLEN-1:0] rs2_value_i,
  output logic [XLEN-1:0] writeback_value_o
);

  // Issue protocol: arith_request_i is a valid with no ready; every cycle it is
  // high at a rising edge is accepted, and its result is visible after that edge.
  // With the request low the output register simply holds.

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   i_imm;
  logic [XLEN-1:0]   u_imm;
  logic              a_sel_pc;
  alu_op_e           op;
  logic [XLEN-1:0]   operand_a;
  logic [XLEN-1:0]   operand_b;
  logic [XLEN-1:0]   alu_result;
  logic              unused_rd;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign i_imm  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign u_imm  = {inst_i[31:12], 12'b0};

  // Destination register handling lives outside this unit.
  assign unused_rd = ^inst_i[11:7];

  // Unsupported opcodes fall through to PASS_B of zero, giving a zero result.
  always_comb begin
    op        = PASS_B;
    a_sel_pc  = 1'b0;
    operand_b = '0;
    case (opcode)
      OPC_OP: begin
        operand_b = rs2_value_i;
        op        = decode_funct3(funct3, inst_i[30], 1'b0);
      end
      OPC_OP_IMM: begin
        operand_b = i_imm;
        op        = decode_funct3(funct3, inst_i[30], 1'b1);
      end
      OPC_LUI: begin
        operand_b = u_imm;
        op        = PASS_B;
      end
      OPC_AUIPC: begin
        operand_b = u_imm;
        a_sel_pc  = 1'b1;
        op        = ADD;
      end
      default: ;
    endcase
  end

  assign operand_a = a_sel_pc ? pc_i : rs1_value_i;

  alu_core u_alu_core (
    .op     (op),
    .a      (operand_a),
    .b      (operand_b),
    .result (alu_result)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      writeback_value_o <= '0;
    end else if (arith_request_i) begin
      writeback_value_o <= alu_result;
    end
  end

endmodule

// File: tb/tb_arith.sv
// Directed bench for arith: hand-computed vectors issued back-to-back, plus hold
// and asynchronous reset checks, with immediate assertions at each check point.
module tb_arith;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] pc_i;
  logic        arith_request_i;
  logic [31:0] inst_i;
  logic [31:0] rs1_value_i;
  logic [31:0] rs2_value_i;
  logic [31:0] writeback_value_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  arith #(.XLEN(32)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .pc_i              (pc_i),
    .arith_request_i   (arith_request_i),
    .inst_i            (inst_i),
    .rs1_value_i       (rs1_value_i),
    .rs2_value_i       (rs2_value_i),
    .writeback_value_o (writeback_value_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (writeback_value_o === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, writeback_value_o, expected);
    end
  endtask

  // Drive one request at the falling edge, then check just after the rising edge.
  task automatic issue(input string tag, input logic [31:0] inst,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] expected);
    logic [31:0] exp_v;
    @(negedge clk_i);
    arith_request_i = 1'b1;
    inst_i          = inst;
    rs1_value_i     = rs1;
    rs2_value_i     = rs2;
    pc_i            = pc;
    exp_q.push_back(expected);
    @(posedge clk_i);
    #1;
    exp_v = exp_q.pop_front();
    check(tag, exp_v);
  endtask

  task automatic idle_cycle(input string tag, input logic [31:0] expected);
    @(negedge clk_i);
    arith_request_i = 1'b0;
    inst_i          = 32'h0000_0033;
    rs1_value_i     = $urandom_range(1, 1000);
    rs2_value_i     = $urandom_range(1, 1000);
    @(posedge clk_i);
    #1;
    check(tag, expected);
  endtask

  initial begin
    reset_i         = 1'b0;
    arith_request_i = 1'b0;
    inst_i          = 32'h0;
    rs1_value_i     = 32'h0;
    rs2_value_i     = 32'h0;
    pc_i            = 32'h0;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_value", 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;

    // core vectors, issued every cycle
    issue("addi",        32'h0051_8093, 32'h0000_0002, 32'h0, 32'h0, 32'h0000_0007);
    issue("slli",        32'h0020_9113, 32'h0000_0005, 32'h0, 32'h0, 32'h0000_0014);
    issue("sub_b2b",     32'h4020_8133, 32'h0000_0010, 32'h5, 32'h0, 32'h0000_000B);
    issue("srai",        32'h4040_5093, 32'h8000_0000, 32'h0, 32'h0, 32'hF800_0000);
    issue("srli",        32'h0040_5093, 32'h8000_0000, 32'h0, 32'h0, 32'h0800_0000);
    issue("slt",         32'h0020_A1B3, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0000_0001);
    issue("sltu",        32'h0020_B1B3, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0000_0000);
    issue("lui",         32'h1234_50B7, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h1234_5000);
    issue("auipc",       32'h0000_1097, 32'hDEAD_BEEF, 32'h0, 32'h8, 32'h0000_1008);

    // further ops and boundaries
    issue("add_wrap",    32'h0020_8133, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0000_0000);
    issue("add_ovf",     32'h0020_8133, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000);
    issue("addi_bit30",  32'h4000_8093, 32'h0000_0001, 32'h0, 32'h0, 32'h0000_0401);
    issue("addi_neg",    32'hFFF0_8093, 32'h0000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF);
    issue("xor",         32'h0020_C133, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0FF0_0FF0);
    issue("or",          32'h0020_E133, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hFFF0_FFF0);
    issue("and",         32'h0020_F133, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'hF000_F000);
    issue("sra_shamt5",  32'h4020_D133, 32'h8000_0000, 32'h24, 32'h0, 32'hF800_0000);
    issue("srl_reg",     32'h0020_D133, 32'h8000_0000, 32'h24, 32'h0, 32'h0800_0000);
    issue("sll_31",      32'h0020_9133, 32'h0000_0001, 32'h3F, 32'h0, 32'h8000_0000);
    issue("xori",        32'hFFF0_C093, 32'h1234_5678, 32'h0, 32'h0, 32'hEDCB_A987);
    issue("sltiu",       32'hFFF0_B093, 32'h0000_0005, 32'h0, 32'h0, 32'h0000_0001);
    issue("slti",        32'hFFF0_A093, 32'h0000_0005, 32'h0, 32'h0, 32'h0000_0000);
    issue("ori_pre",     32'h0FF0_E093, 32'h0000_0000, 32'h0, 32'h0, 32'h0000_00FF);
    issue("unsupported", 32'h0000_0073, 32'h1111_1111, 32'h2222_2222, 32'h4, 32'h0000_0000);

    // hold with request low
    issue("hold_pre",    32'hABCD_E0B7, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
    idle_cycle("hold_1", 32'hABCD_E000);
    idle_cycle("hold_2", 32'hABCD_E000);

    // asynchronous reset between edges
    @(negedge clk_i);
    arith_request_i = 1'b1;
    inst_i          = 32'h0051_8093;
    rs1_value_i     = 32'h0000_0002;
    #2;
    reset_i = 1'b0;
    #1;
    check("async_reset", 32'h0);
    @(posedge clk_i);
    #1;
    check("reset_held", 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;
    issue("after_reset", 32'h0051_8093, 32'h0000_0002, 32'h0, 32'h0, 32'h0000_0007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
